// File: rtl/elevator_pkg.sv
// ----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the SCAN elevator controller:
//   - state_t   : controller FSM states
//   - MOTOR_*   : motor command encodings (2 bits, 11 is never driven)
//   - onehot()  : one-hot helper used to match single-floor sensor pulses
// ----------------------------------------------------------------------------
package elevator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_UP   = 2'd1,
    ST_MOVE_DOWN = 2'd2,
    ST_DOOR      = 2'd3
  } state_t;

  localparam logic [1:0] MOTOR_STOP = 2'b00;
  localparam logic [1:0] MOTOR_UP   = 2'b01;
  localparam logic [1:0] MOTOR_DOWN = 2'b10;

  // Wide enough for any supported floor count; indices past the top give 0.
  localparam int ONEHOT_W = 64;

  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    logic [ONEHOT_W-1:0] v;
    v = {{(ONEHOT_W-1){1'b0}}, 1'b1} << idx;
    return v;
  endfunction

endpackage

// File: rtl/elevator_req_bank.sv
// ----------------------------------------------------------------------------
// elevator_req_bank
// Per-floor request registers (car, hall up, hall down) and the position
// reductions used by the controller.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   i_set_car/up/down         : raw call inputs, OR-ed into the registers
//   i_clr_car/up/down         : per-floor clears; a clear beats a same-cycle set
//   i_query                   : floor index the reductions are evaluated at
//   o_car/o_up/o_down         : latched request vectors (lamp outputs)
//   o_above/o_below/o_here    : any request above / below / at i_query
// ----------------------------------------------------------------------------
module elevator_req_bank
  import elevator_pkg::*;
#(
  parameter int FLOORS = 4,
  parameter int FW     = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] i_set_car,
  input  logic [FLOORS-1:0] i_set_up,
  input  logic [FLOORS-1:0] i_set_down,
  input  logic [FLOORS-1:0] i_clr_car,
  input  logic [FLOORS-1:0] i_clr_up,
  input  logic [FLOORS-1:0] i_clr_down,
  input  logic [FW-1:0]     i_query,
  output logic [FLOORS-1:0] o_car,
  output logic [FLOORS-1:0] o_up,
  output logic [FLOORS-1:0] o_down,
  output logic              o_above,
  output logic              o_below,
  output logic              o_here
);

  // The top floor has no up button and floor 0 has no down button.
  localparam logic [FLOORS-1:0] UP_MASK = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK = {{(FLOORS-1){1'b1}}, 1'b0};

  logic [FLOORS-1:0] r_car;
  logic [FLOORS-1:0] r_up;
  logic [FLOORS-1:0] r_down;
  logic [FLOORS-1:0] w_any;

  // Request registers: latch new calls, clear served floors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_car  <= {FLOORS{1'b0}};
      r_up   <= {FLOORS{1'b0}};
      r_down <= {FLOORS{1'b0}};
    end else begin
      r_car  <= (r_car  | i_set_car)              & ~i_clr_car;
      r_up   <= (r_up   | (i_set_up   & UP_MASK)) & ~i_clr_up;
      r_down <= (r_down | (i_set_down & DN_MASK)) & ~i_clr_down;
    end
  end

  assign o_car  = r_car;
  assign o_up   = r_up;
  assign o_down = r_down;
  assign w_any  = r_car | r_up | r_down;

  // Position reductions relative to the queried floor.
  always_comb begin
    o_above = 1'b0;
    o_below = 1'b0;
    o_here  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(i_query)) begin
        o_above = o_above | w_any[i];
      end else if (i < int'(i_query)) begin
        o_below = o_below | w_any[i];
      end else begin
        o_here = o_here | w_any[i];
      end
    end
  end

endmodule

// File: rtl/elevator_scan.sv
// ----------------------------------------------------------------------------
// elevator_scan
// N-floor SCAN (collective) elevator controller.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   sensor                   : one-cycle pulse, bit k = cabin reached floor k
//   car_call                 : cabin floor buttons
//   hall_up / hall_down      : hall buttons (top-up and bottom-down ignored)
//   motor                    : 00 stop, 01 up, 10 down
//   display                  : current floor index
//   door_open                : door command
//   car_lamp/up_lamp/down_lamp : latched request registers
// ----------------------------------------------------------------------------
module elevator_scan
  import elevator_pkg::*;
#(
  parameter int FLOORS      = 4,
  parameter int DOOR_CYCLES = 8,
  parameter int FW          = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] sensor,
  input  logic [FLOORS-1:0] car_call,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_down,
  output logic [1:0]        motor,
  output logic [FW-1:0]     display,
  output logic              door_open,
  output logic [FLOORS-1:0] car_lamp,
  output logic [FLOORS-1:0] up_lamp,
  output logic [FLOORS-1:0] down_lamp
);

  localparam int                CW         = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_LOAD   = CW'(DOOR_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1);
  localparam logic [FW-1:0]     FLOOR_ZERO = FW'(0);
  localparam logic [FW-1:0]     FLOOR_ONE  = FW'(1);
  localparam logic [FW-1:0]     FLOOR_TOP  = FW'(FLOORS - 1);
  localparam logic [FLOORS-1:0] BIT0       = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [FLOORS-1:0] UP_MASK    = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_MASK    = {{(FLOORS-1){1'b1}}, 1'b0};

  state_t              r_state, w_state_nx;
  logic [FW-1:0]       r_floor, w_floor_nx;
  logic                r_dir, w_dir_nx;      // 1 = up
  logic [CW-1:0]       r_cnt, w_cnt_nx;
  logic [1:0]          r_motor, w_motor_nx;
  logic                r_door_open;

  logic [FW-1:0]       w_floor_up, w_floor_dn, w_query;
  logic [ONEHOT_W-1:0] w_sensor_ext;
  logic                w_up_hit, w_dn_hit, w_reload;
  logic [FLOORS-1:0]   w_oh_q, w_hup_m, w_hdn_m;
  logic [FLOORS-1:0]   w_clr_car, w_clr_up, w_clr_down;
  logic [FLOORS-1:0]   w_car, w_up, w_down;
  logic                w_above, w_below, w_here;
  logic                w_k_car, w_k_up, w_k_down;

  elevator_req_bank #(.FLOORS(FLOORS), .FW(FW)) u_req_bank (
    .clk        (clk),
    .rst        (rst),
    .i_set_car  (car_call),
    .i_set_up   (hall_up),
    .i_set_down (hall_down),
    .i_clr_car  (w_clr_car),
    .i_clr_up   (w_clr_up),
    .i_clr_down (w_clr_down),
    .i_query    (w_query),
    .o_car      (w_car),
    .o_up       (w_up),
    .o_down     (w_down),
    .o_above    (w_above),
    .o_below    (w_below),
    .o_here     (w_here)
  );

  assign w_floor_up   = r_floor + FLOOR_ONE;
  assign w_floor_dn   = r_floor - FLOOR_ONE;
  assign w_sensor_ext = ONEHOT_W'(sensor);

  // Only the exact next floor in the direction of travel is accepted; the
  // boundary guards keep floor from wrapping.
  assign w_up_hit = (r_state == ST_MOVE_UP) && (r_floor != FLOOR_TOP) &&
                    (w_sensor_ext == onehot(32'(r_floor) + 32'd1));
  assign w_dn_hit = (r_state == ST_MOVE_DOWN) && (r_floor != FLOOR_ZERO) &&
                    (w_sensor_ext == onehot(32'(r_floor) - 32'd1));

  // Reductions are taken at the arriving floor on a valid sensor pulse so the
  // stop decision sees above_k / below_k of the new floor.
  always_comb begin
    w_query = r_floor;
    if (w_up_hit) begin
      w_query = w_floor_up;
    end else if (w_dn_hit) begin
      w_query = w_floor_dn;
    end else begin
      w_query = r_floor;
    end
  end

  assign w_oh_q   = BIT0 << w_query;
  assign w_k_car  = w_car[w_query];
  assign w_k_up   = w_up[w_query];
  assign w_k_down = w_down[w_query];
  assign w_hup_m  = hall_up & UP_MASK;
  assign w_hdn_m  = hall_down & DN_MASK;

  // With the door open, a car call here or a hall call matching dir keeps it open.
  assign w_reload = (r_state == ST_DOOR) &&
                    (car_call[r_floor] || (r_dir && w_hup_m[r_floor]) ||
                     (!r_dir && w_hdn_m[r_floor]));

  // Next-state, floor, direction, door counter and request clears.
  always_comb begin
    w_state_nx = r_state;
    w_floor_nx = r_floor;
    w_dir_nx   = r_dir;
    w_cnt_nx   = r_cnt;
    w_clr_car  = {FLOORS{1'b0}};
    w_clr_up   = {FLOORS{1'b0}};
    w_clr_down = {FLOORS{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_here) begin
          w_state_nx = ST_DOOR;
          w_cnt_nx   = CNT_LOAD;
          w_clr_car  = w_oh_q;
          w_clr_up   = w_oh_q;
          w_clr_down = w_oh_q;
        end else if (w_above && w_below) begin
          w_state_nx = r_dir ? ST_MOVE_UP : ST_MOVE_DOWN;
        end else if (w_above) begin
          w_state_nx = ST_MOVE_UP;
          w_dir_nx   = 1'b1;
        end else if (w_below) begin
          w_state_nx = ST_MOVE_DOWN;
          w_dir_nx   = 1'b0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_MOVE_UP: begin
        if (w_up_hit) begin
          w_floor_nx = w_floor_up;
          if (w_k_car || w_k_up || (w_k_down && !w_above)) begin
            w_state_nx = ST_DOOR;
            w_cnt_nx   = CNT_LOAD;
            w_clr_car  = w_oh_q;
            w_clr_up   = w_oh_q;
            // Nothing further up: this is the turnaround, so take the down call too.
            if (!w_above) begin
              w_clr_down = w_oh_q;
              w_dir_nx   = 1'b0;
            end else begin
              w_dir_nx   = r_dir;
            end
          end else begin
            w_state_nx = ST_MOVE_UP;
          end
        end else begin
          w_state_nx = ST_MOVE_UP;
        end
      end
      ST_MOVE_DOWN: begin
        if (w_dn_hit) begin
          w_floor_nx = w_floor_dn;
          if (w_k_car || w_k_down || (w_k_up && !w_below)) begin
            w_state_nx = ST_DOOR;
            w_cnt_nx   = CNT_LOAD;
            w_clr_car  = w_oh_q;
            w_clr_down = w_oh_q;
            if (!w_below) begin
              w_clr_up = w_oh_q;
              w_dir_nx = 1'b1;
            end else begin
              w_dir_nx = r_dir;
            end
          end else begin
            w_state_nx = ST_MOVE_DOWN;
          end
        end else begin
          w_state_nx = ST_MOVE_DOWN;
        end
      end
      ST_DOOR: begin
        // Calls that would reload the door are never latched here.
        w_clr_car = w_oh_q;
        if (r_dir) begin
          w_clr_up = w_oh_q;
        end else begin
          w_clr_down = w_oh_q;
        end
        if (w_reload) begin
          w_cnt_nx = CNT_LOAD;
        end else if (r_cnt != CNT_ZERO) begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end else if (r_dir ? w_above : w_below) begin
          w_state_nx = r_dir ? ST_MOVE_UP : ST_MOVE_DOWN;
        end else if (r_dir ? w_below : w_above) begin
          w_dir_nx   = !r_dir;
          w_state_nx = r_dir ? ST_MOVE_DOWN : ST_MOVE_UP;
        end else if (w_here) begin
          // Opposite-direction hall call at this floor: serve it without moving.
          w_cnt_nx   = CNT_LOAD;
          w_dir_nx   = !r_dir;
          w_clr_car  = w_oh_q;
          w_clr_up   = w_oh_q;
          w_clr_down = w_oh_q;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Motor command derived from the next state so it is registered with it.
  always_comb begin
    w_motor_nx = MOTOR_STOP;
    case (w_state_nx)
      ST_MOVE_UP:   w_motor_nx = MOTOR_UP;
      ST_MOVE_DOWN: w_motor_nx = MOTOR_DOWN;
      default:      w_motor_nx = MOTOR_STOP;
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_floor     <= FLOOR_ZERO;
      r_dir       <= 1'b1;
      r_cnt       <= CNT_ZERO;
      r_motor     <= MOTOR_STOP;
      r_door_open <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_floor     <= w_floor_nx;
      r_dir       <= w_dir_nx;
      r_cnt       <= w_cnt_nx;
      r_motor     <= w_motor_nx;
      r_door_open <= (w_state_nx == ST_DOOR);
    end
  end

  assign motor     = r_motor;
  assign display   = r_floor;
  assign door_open = r_door_open;
  assign car_lamp  = w_car;
  assign up_lamp   = w_up;
  assign down_lamp = w_down;

endmodule

// File: tb/tb_elevator_scan.sv
// ----------------------------------------------------------------------------
// tb_elevator_scan
// Directed, table-driven bench for elevator_scan (FLOORS=4, DOOR_CYCLES=4).
// Each vector drives inputs for one cycle; outputs are compared 1 time unit
// after the following rising edge.
// ----------------------------------------------------------------------------
module tb_elevator_scan;

  logic       clk;
  logic       rst;
  logic [3:0] sensor, car_call, hall_up, hall_down;
  logic [1:0] motor;
  logic [1:0] display;
  logic       door_open;
  logic [3:0] car_lamp, up_lamp, down_lamp;

  int n_checks;
  int n_errors;

  elevator_scan #(.FLOORS(4), .DOOR_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor    (sensor),
    .car_call  (car_call),
    .hall_up   (hall_up),
    .hall_down (hall_down),
    .motor     (motor),
    .display   (display),
    .door_open (door_open),
    .car_lamp  (car_lamp),
    .up_lamp   (up_lamp),
    .down_lamp (down_lamp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       r;
    logic [3:0] s, c, u, d;
    logic [1:0] m;
    logic [1:0] disp;
    logic       door;
    logic [3:0] cl, ul, dl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] s, c, u, d,
                     input logic [1:0] m, input logic [1:0] disp, input logic door,
                     input logic [3:0] cl, ul, dl);
    vec_t v;
    v.r = r; v.s = s; v.c = c; v.u = u; v.d = d;
    v.m = m; v.disp = disp; v.door = door; v.cl = cl; v.ul = ul; v.dl = dl;
    vecs.push_back(v);
  endtask

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL vec%0d %s: got %0h expected %0h", id, nm, act, exp);
    end
  endtask

  task automatic check_all(input int id, input logic [1:0] m, input logic [1:0] disp,
                           input logic door, input logic [3:0] cl, ul, dl);
    chk(id, "motor",     32'(motor),     32'(m));
    chk(id, "display",   32'(display),   32'(disp));
    chk(id, "door_open", 32'(door_open), 32'(door));
    chk(id, "car_lamp",  32'(car_lamp),  32'(cl));
    chk(id, "up_lamp",   32'(up_lamp),   32'(ul));
    chk(id, "down_lamp", 32'(down_lamp), 32'(dl));
  endtask

  // Drive one cycle of inputs, step past the edge, then return inputs to idle.
  task automatic cyc(input logic r, input logic [3:0] s, c, u, d);
    rst = r; sensor = s; car_call = c; hall_up = u; hall_down = d;
    @(posedge clk);
    #1;
    rst = 1'b0; sensor = 4'b0000; car_call = 4'b0000; hall_up = 4'b0000; hall_down = 4'b0000;
  endtask

  int open_cnt;
  int lamp_bad;
  bit done;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; sensor = 4'b0000; car_call = 4'b0000; hall_up = 4'b0000; hall_down = 4'b0000;

    // ---- simple trip 0 -> 2 (vectors 0..9) ----
    add(1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 2'b00, 2'd0, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'd0, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    add(1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'd1, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'd1, 1'b0, 4'b0000, 4'b0100, 4'b0000);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++)
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ---- ignored hall buttons hall_up[3], hall_down[0] ----
    add(1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 2'b00, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ---- reset back to floor 0 ----
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    // ---- collective order ----
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'b00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b1000);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b1000);
    add(1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2'b01, 2'd0, 1'b0, 4'b0000, 4'b0100, 4'b1000);
    add(1'b0, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'd0, 1'b0, 4'b0000, 4'b0100, 4'b1000);
    add(1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'd1, 1'b0, 4'b0000, 4'b0100, 4'b1000);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b1000);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'b00, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b1010);
    for (int i = 0; i < 2; i++)
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd2, 1'b1, 4'b0000, 4'b0000, 4'b1010);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b01, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b1010);
    add(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd3, 1'b1, 4'b0000, 4'b0000, 4'b0010);
    for (int i = 0; i < 3; i++)
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd3, 1'b1, 4'b0000, 4'b0000, 4'b0010);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b10, 2'd3, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    add(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 2'b10, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0010);
    add(1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++)
      add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    add(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'b00, 2'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // ---- reset, then idle for 10 cycles ----
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check_all(100, 2'b00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      check_all(101 + i, 2'b00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    end

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].r, vecs[i].s, vecs[i].c, vecs[i].u, vecs[i].d);
      check_all(i, vecs[i].m, vecs[i].disp, vecs[i].door, vecs[i].cl, vecs[i].ul, vecs[i].dl);
    end

    // ---- door reload at floor 1: car_call[1] in the 3rd open cycle ----
    cyc(1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    check_all(200, 2'b00, 2'd1, 1'b0, 4'b0010, 4'b0000, 4'b0000);
    open_cnt = 0;
    lamp_bad = 0;
    done     = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      if (door_open === 1'b1) begin
        open_cnt++;
        if (car_lamp !== 4'b0000 || motor !== 2'b00) lamp_bad++;
        car_call = (open_cnt == 3) ? 4'b0010 : 4'b0000;
      end else begin
        done = 1'b1;
      end
    end
    car_call = 4'b0000;
    chk(201, "reload_open_cycles", 32'(open_cnt), 32'd7);
    chk(202, "reload_lamp_motor_bad", 32'(lamp_bad), 32'd0);
    check_all(203, 2'b00, 2'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // ---- reset while moving down with pending calls ----
    cyc(1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    check_all(300, 2'b00, 2'd1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check_all(301, 2'b10, 2'd1, 1'b0, 4'b0001, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    check_all(302, 2'b10, 2'd1, 1'b0, 4'b0001, 4'b0100, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    check_all(303, 2'b00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    check_all(304, 2'b00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      check_all(305 + i, 2'b00, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_scan.md
# elevator_scan

N-floor elevator controller, the parametrised successor of the 3-floor `elevator` block. It latches car calls and hall up/down calls into per-floor request registers and serves them in SCAN (collective) order, continuing in the current direction while any request remains ahead. It drives motor direction, the floor display and a timed door output, and exposes the latched request lamps. It sits between the floor sensors and call buttons on one side and the motor, door and indicator drivers on the other.

## Interface
- `FLOORS`, default 4: number of floors; must be ≥ 2.
- `DOOR_CYCLES`, default 8: cycles `door_open` stays high per stop; must be ≥ 1.
- `FW`, default `$clog2(FLOORS)`: floor index width.

- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sensor` in FLOORS: one-cycle pulse, bit k set when the cabin reaches floor k.
- `car_call` in FLOORS: cabin floor buttons (pulse or level).
- `hall_up` in FLOORS: up buttons. Bit FLOORS-1 is ignored.
- `hall_down` in FLOORS: down buttons. Bit 0 is ignored.
- `motor` out 2: 00 stop, 01 up, 10 down. 11 is never driven.
- `display` out FW: current floor index.
- `door_open` out 1: door open command.
- `car_lamp`, `up_lamp`, `down_lamp` out FLOORS: latched request registers.

## Operation
- **States:** IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- **Registers:** `floor`, `dir` (last travel direction, 1 = up), door counter, and the three request vectors.
- **Reset values:** state IDLE, `floor`=0, `dir`=up, `motor`=00, `door_open`=0, `display`=0, all lamps 0. Reset defines the cabin position as floor 0 and discards all pending requests, whatever the state at the time.
- **Latching:** each cycle, `req |= input`. Ignored bits (`hall_up[FLOORS-1]`, `hall_down[0]`) are never set.
- **Reductions:**
  - `above` = any request at a floor > `floor`.
  - `below` = any request at a floor < `floor`.
  - `here` = any request at `floor`.
- **IDLE:**
  - If `here`: go to DOOR and clear all three requests at `floor`.
  - Else if `above` and `below`: move in `dir`.
  - Else if only `above`: MOVE_UP. Else if only `below`: MOVE_DOWN.
  - Entering a MOVE state sets `dir` to match.
- **MOVE_UP:**
  - Only `sensor == onehot(floor+1)` is honoured. It sets `floor++`.
  - Stop (go to DOOR) at new floor k if `car[k] | up[k] | (down[k] & ~above_k)`, where `above_k` is `above` evaluated at k.
  - On stop: clear `car[k]`. Clear `up[k]`. Clear `down[k]` only if `~above_k`; then `dir` becomes down.
  - Otherwise stay in MOVE_UP.
- **MOVE_DOWN:** mirror of MOVE_UP. Honour `onehot(floor-1)`; stop if `car[k] | down[k] | (up[k] & ~below_k)`.
- **Ignored sensor pulses:** any other pulse (wrong floor, multiple bits, or arriving in IDLE/DOOR) is ignored. `floor` is unchanged.
- **DOOR:**
  - `door_open` = 1 and `motor` = 00.
  - The counter loads `DOOR_CYCLES-1` on entry and decrements each cycle.
  - A call at `floor` that is consistent with `dir`, or any car call at `floor`, reloads the counter. That request is not latched (the clear wins over a simultaneous set).
  - When the counter reaches 0:
    - If a request remains ahead in `dir`: move in `dir`.
    - Else if a request remains in the opposite direction: flip `dir` and move.
    - Else if `here` (an opposite-direction hall call at this floor): serve it in place. Stay in DOOR, reload the counter, flip `dir` and clear that call.
    - Else: IDLE.
- **Boundaries:**
  - Floor 0 never has `below`; floor FLOORS-1 never has `above`.
  - `floor` never wraps.

## Timing
- All outputs are registered.
- A button pulse in cycle t sets its lamp at edge t+1. The state decision uses the lamps, so `motor` or `door_open` changes at edge t+2 at the earliest.
- A valid sensor pulse in cycle t updates `display` at edge t+1. If that floor is a stop, `motor`=00 and `door_open`=1 at the same edge t+1.
- `door_open` is high exactly DOOR_CYCLES consecutive cycles per stop without reload. `motor` leaves 00 on the edge where `door_open` falls.
- While `rst` is high, outputs hold their reset values; inputs are not latched.

## Structure
- Package `elevator_pkg`: the state enum; motor encodings `MOTOR_STOP`/`MOTOR_UP`/`MOTOR_DOWN`; the `onehot` helper function.
- Sub-module `elevator_req_bank` (parameter FLOORS):
  - Holds the three request registers: latch, masked set, per-floor clear.
  - Produces the `above`/`below`/`here` reductions for a given floor index.
- The top level holds the FSM, floor register, `dir` and door counter.

## Test plan
All scenarios use FLOORS=4, DOOR_CYCLES=4.
- **Reset idle:** reset, then idle 10 cycles → `motor`=00, `display`=0, `door_open`=0, all lamps 0.
- **Simple trip:** `hall_up[2]` pulse → `up_lamp`=0100, then `motor`=01. Sensor pulses 0010 then 0100 → `display` 1 then 2, stop at 2. `door_open` high 4 cycles, lamp cleared, then IDLE.
- **Collective order:** at floor 0, `hall_down[3]`, then `hall_up[2]` while moving up.
  - Stops at 2 (up call cleared), continues to 3 (down call cleared, `dir` down).
  - A `hall_down[1]` pressed at floor 2 is served on the way down.
- **Ignored inputs:**
  - Sensor 0100 while at floor 0 moving up, or sensor 0011 → `display` unchanged.
  - `hall_down[0]` and `hall_up[3]` → lamps stay 0.
- **Door reload:** `car_call[floor]` in the 3rd open cycle → `door_open` stays high 4 more cycles; lamp never sets.
- **Reset mid-travel:** `rst` during MOVE_DOWN with pending calls → next edge: `motor`=00, `display`=0, lamps 0. A `hall_down[3]` press while `rst` is high is not latched.
